cfa_window_5x5: RTL

Streaming 5x5 window generator that drives the gradients_2 patch inputs from a raster pixel stream. It replaces the file-driven patch feed with hardware.
- Accepts one 12-bit Bayer pixel per valid cycle, in row-major order.
- Buffers four full lines.
- Presents the 25-pixel neighbourhood of the centre pixel, with a one-cycle start strobe, whenever a complete interior window exists.

---
 rtl/cfa_pkg.sv | 18 +
 rtl/cfa_line_buf.sv | 42 ++++
 rtl/cfa_window_5x5.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cfa_pkg.sv
// Shared constants, FSM state type and window slot indexing for the CFA 5x5 window generator.
package cfa_pkg;

  localparam int unsigned PixWDefault = 12;
  localparam int unsigned WinDim      = 5;
  localparam int unsigned WinSlots    = WinDim * WinDim;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } cfa_state_e;

  // Slot of neighbour (r, c), r/c in -2..2, inside the flattened 5x5 window.
  function automatic logic [4:0] idx(input int r, input int c);
    return 5'((r + 2) * int'(WinDim) + (c + 2));
  endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Single-line pixel delay: the output is the pixel written DEPTH enabled writes earlier.
module cfa_line_buf #(
  parameter int unsigned PIX_W = 12,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (we_i) begin
      ptr_d = (ptr_q == AddrW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately not reset; stale contents are masked by window-valid logic.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/cfa_window_5x5.sv
// Streaming 5x5 Bayer window generator: four line buffers plus a shifting 5x5 register array.
// Optional macro CFA_BAYER_PHASE_EN adds the bayer_phase output.
module cfa_window_5x5
  import cfa_pkg::*;
#(
  parameter int unsigned PIX_W = PixWDefault,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic                      sof,
  input  logic [PIX_W-1:0]          pix_in,
  output logic [WinSlots*PIX_W-1:0] win_out,
  output logic                      start,
  output logic [15:0]               ctr_row,
  output logic [15:0]               ctr_col,
  output logic                      frame_done
`ifdef CFA_BAYER_PHASE_EN
  ,
  output logic [1:0]                bayer_phase
`endif
);

  cfa_state_e state_q, state_d;
  logic       accept;

  logic [15:0] row_q, row_d, col_q, col_d;
  logic [15:0] pos_row, pos_col;
  logic        last_row, last_col;
  logic        win_valid, frame_done_d;

  logic [PIX_W-1:0] line_in  [4];
  logic [PIX_W-1:0] line_out [4];
  logic [PIX_W-1:0] col_new  [WinDim];

  logic [PIX_W-1:0] win_q     [WinSlots];
  logic [PIX_W-1:0] win_d     [WinSlots];
  logic [PIX_W-1:0] win_out_q [WinSlots];

  logic        start_q, frame_done_q;
  logic [15:0] ctr_row_q, ctr_col_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pix_valid && sof) state_d = StRun;
      StRun:  if (accept && last_row && last_col) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // In IDLE only a sof pixel is taken; anything else is dropped.
  always_comb begin
    accept = pix_valid && (sof || (state_q == StRun));
  end

  // ---------------------------------------------------------------- counters
  always_comb begin
    pos_row  = sof ? 16'd0 : row_q;
    pos_col  = sof ? 16'd0 : col_q;
    last_col = (pos_col == 16'(IMG_W - 1));
    last_row = (pos_row == 16'(IMG_H - 1));
    row_d    = row_q;
    col_d    = col_q;
    if (accept) begin
      if (last_col) begin
        col_d = 16'd0;
        row_d = last_row ? 16'd0 : pos_row + 16'd1;
      end else begin
        col_d = pos_col + 16'd1;
        row_d = pos_row;
      end
    end
    win_valid    = accept && (pos_row >= 16'd4) && (pos_col >= 16'd4);
    frame_done_d = accept && last_row && last_col;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // ---------------------------------------------------------------- line buffers
  always_comb begin
    line_in[0] = pix_in;
    for (int j = 1; j < 4; j++) begin
      line_in[j] = line_out[j-1];
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_line
    cfa_line_buf #(
      .PIX_W (PIX_W),
      .DEPTH (IMG_W)
    ) u_line_buf (
      .clk_i  (clk),
      .rst_ni (rst),
      .we_i   (accept),
      .din_i  (line_in[j]),
      .dout_o (line_out[j])
    );
  end

  // ---------------------------------------------------------------- window array
  always_comb begin
    col_new[0] = line_out[3];
    col_new[1] = line_out[2];
    col_new[2] = line_out[1];
    col_new[3] = line_out[0];
    col_new[4] = pix_in;
    win_d = win_q;
    if (accept) begin
      for (int r = -2; r <= 2; r++) begin
        for (int c = -2; c < 2; c++) begin
          win_d[idx(r, c)] = win_q[idx(r, c + 1)];
        end
        win_d[idx(r, 2)] = col_new[r+2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(WinSlots); k++) begin
        win_q[k]     <= '0;
        win_out_q[k] <= '0;
      end
    end else begin
      win_q <= win_d;
      // Presented window only changes on a valid interior centre.
      if (win_valid) begin
        win_out_q <= win_d;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
    end else begin
      start_q      <= win_valid;
      frame_done_q <= frame_done_d;
      if (win_valid) begin
        ctr_row_q <= pos_row - 16'd2;
        ctr_col_q <= pos_col - 16'd2;
      end
    end
  end

`ifdef CFA_BAYER_PHASE_EN
  logic [1:0] bayer_phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bayer_phase_q <= '0;
    end else if (win_valid) begin
      bayer_phase_q <= {pos_row[0], pos_col[0]};
    end
  end

  assign bayer_phase = bayer_phase_q;
`endif

  always_comb begin
    for (int k = 0; k < int'(WinSlots); k++) begin
      win_out[k*PIX_W +: PIX_W] = win_out_q[k];
    end
  end

  assign start      = start_q;
  assign frame_done = frame_done_q;
  assign ctr_row    = ctr_row_q;
  assign ctr_col    = ctr_col_q;

endmodule
